fix_field_splitter: RTL and testbench

Front-end tokenizer of the FIX parser. Consumes the raw FIX byte stream, one byte per valid cycle, and splits each "tag=value<SOH>" field. It converts the ASCII tag number to binary and forwards value bytes with a field-end marker. Value bytes feed the downstream ASCII-to-integer converter and the message decoder.

---
 rtl/fix_field_splitter.sv | 192 +++++++++++++++++++
 tb/tb_fix_field_splitter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_field_splitter.sv
// fix_field_splitter: FIX "tag=value<SOH>" tokenizer.
// Takes one raw FIX byte per valid cycle. The ASCII tag number is
// converted to binary. Value bytes are forwarded with a field-end marker
// and the value byte count.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   data_i       incoming FIX byte
//   valid_i      data_i valid this cycle (always consumed)
//   tag_o        binary tag of the current field, held until the next tag_valid_o
//   tag_valid_o  1-cycle pulse, tag_o updated
//   val_data_o   value byte
//   val_valid_o  val_data_o valid this cycle
//   field_end_o  1-cycle pulse, SOH closed a well-formed field
//   val_len_o    value byte count, valid with field_end_o
//   err_o        1-cycle pulse, malformed field detected
module fix_field_splitter #(
  parameter int unsigned MAX_TAG_DIGITS = 5,
  parameter int unsigned TAG_W          = 17,
  parameter int unsigned MAX_VAL_LEN    = 64,
  parameter int unsigned LEN_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             tag_valid_o,
  output logic [7:0]       val_data_o,
  output logic             val_valid_o,
  output logic             field_end_o,
  output logic [LEN_W-1:0] val_len_o,
  output logic             err_o
);

  localparam int unsigned DCNT_W = $clog2(MAX_TAG_DIGITS + 1);
  localparam int unsigned MUL_W  = TAG_W + 4;

  localparam logic [7:0] CH_SOH  = 8'h01;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_NINE = 8'h39;

  typedef enum logic [1:0] {
    ST_TAG   = 2'd0,
    ST_VALUE = 2'd1,
    ST_SKIP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    acc_q, acc_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                tag_valid_q, tag_valid_d;
  logic [7:0]          val_data_q, val_data_d;
  logic                val_valid_q, val_valid_d;
  logic                field_end_q, field_end_d;
  logic [LEN_W-1:0]    val_len_q, val_len_d;
  logic                err_q, err_d;

  logic is_digit_c;
  logic is_soh_c;
  logic is_eq_c;
  logic raise_err_c;

  assign is_digit_c = (data_i >= CH_ZERO) && (data_i <= CH_NINE);
  assign is_soh_c   = (data_i == CH_SOH);
  assign is_eq_c    = (data_i == CH_EQ);

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_TAG;
      acc_q       <= '0;
      dcnt_q      <= '0;
      len_q       <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      val_data_q  <= '0;
      val_valid_q <= 1'b0;
      field_end_q <= 1'b0;
      val_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dcnt_q      <= dcnt_d;
      len_q       <= len_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      val_data_q  <= val_data_d;
      val_valid_q <= val_valid_d;
      field_end_q <= field_end_d;
      val_len_q   <= val_len_d;
      err_q       <= err_d;
    end
  end

  // Next-state and output decode; pulses default low, data outputs hold
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    dcnt_d      = dcnt_q;
    len_d       = len_q;
    tag_d       = tag_q;
    tag_valid_d = 1'b0;
    val_data_d  = val_data_q;
    val_valid_d = 1'b0;
    field_end_d = 1'b0;
    val_len_d   = val_len_q;
    err_d       = 1'b0;
    raise_err_c = 1'b0;

    if (valid_i) begin
      unique case (state_q)
        ST_TAG: begin
          if (is_digit_c) begin
            // Digit limit is checked before the multiply, so acc cannot overflow
            if (dcnt_q == DCNT_W'(MAX_TAG_DIGITS)) begin
              raise_err_c = 1'b1;
            end else begin
              acc_d  = TAG_W'(MUL_W'(acc_q) * MUL_W'(10) + MUL_W'(data_i[3:0]));
              dcnt_d = dcnt_q + DCNT_W'(1);
            end
          end else if (is_eq_c) begin
            if (dcnt_q == '0) begin
              raise_err_c = 1'b1;
            end else begin
              tag_d       = acc_q;
              tag_valid_d = 1'b1;
              acc_d       = '0;
              dcnt_d      = '0;
              len_d       = '0;
              state_d     = ST_VALUE;
            end
          end else begin
            // SOH or any other byte
            raise_err_c = 1'b1;
          end
        end

        ST_VALUE: begin
          if (is_soh_c) begin
            if (len_q == '0) begin
              raise_err_c = 1'b1;
            end else begin
              field_end_d = 1'b1;
              val_len_d   = len_q;
              len_d       = '0;
              state_d     = ST_TAG;
            end
          end else if (len_q < LEN_W'(MAX_VAL_LEN)) begin
            val_data_d  = data_i;
            val_valid_d = 1'b1;
            len_d       = len_q + LEN_W'(1);
          end else begin
            raise_err_c = 1'b1;
          end
        end

        ST_SKIP: begin
          if (is_soh_c) begin
            state_d = ST_TAG;
          end
        end

        default: begin
          state_d = ST_TAG;
        end
      endcase

      // An SOH already terminates the field, so there is nothing to skip
      if (raise_err_c) begin
        err_d   = 1'b1;
        acc_d   = '0;
        dcnt_d  = '0;
        len_d   = '0;
        state_d = is_soh_c ? ST_TAG : ST_SKIP;
      end
    end
  end

  assign tag_o       = tag_q;
  assign tag_valid_o = tag_valid_q;
  assign val_data_o  = val_data_q;
  assign val_valid_o = val_valid_q;
  assign field_end_o = field_end_q;
  assign val_len_o   = val_len_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fix_field_splitter.sv
// Testbench for fix_field_splitter: expected output events are queued as
// stimulus is driven and checked in order as the DUT pulses its outputs.
module tb_fix_field_splitter;

  localparam int unsigned TAG_W = 17;
  localparam int unsigned LEN_W = 7;

  localparam logic [1:0] K_TAG = 2'd0;
  localparam logic [1:0] K_VAL = 2'd1;
  localparam logic [1:0] K_END = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } ev_t;

  logic             clk;
  logic             rst;
  logic [7:0]       data_i;
  logic             valid_i;
  logic [TAG_W-1:0] tag_o;
  logic             tag_valid_o;
  logic [7:0]       val_data_o;
  logic             val_valid_o;
  logic             field_end_o;
  logic [LEN_W-1:0] val_len_o;
  logic             err_o;

  int  pass_cnt = 0;
  int  chk_cnt  = 0;
  ev_t exp_q[$];
  logic cap_valid = 1'b0;

  fix_field_splitter dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .tag_o       (tag_o),
    .tag_valid_o (tag_valid_o),
    .val_data_o  (val_data_o),
    .val_valid_o (val_valid_o),
    .field_end_o (field_end_o),
    .val_len_o   (val_len_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // valid_i as captured by the DUT on this edge (inputs change #1 after)
  always @(posedge clk) cap_valid = valid_i;

  // Output monitor / scoreboard
  always @(negedge clk) begin
    int   npulse;
    ev_t  obs;
    ev_t  e;
    if (rst) begin
      npulse = int'(tag_valid_o) + int'(val_valid_o) + int'(field_end_o) + int'(err_o);
      if (!cap_valid) begin
        chk_cnt++;
        if (npulse != 0)
          $display("FAIL idle_pulse: got %0d pulses on idle cycle, expected 0 (t=%0t)", npulse, $time);
        else
          pass_cnt++;
      end else if (npulse > 0) begin
        if (tag_valid_o)      obs = '{K_TAG, 32'(tag_o)};
        else if (val_valid_o) obs = '{K_VAL, 32'(val_data_o)};
        else if (field_end_o) obs = '{K_END, 32'(val_len_o)};
        else                  obs = '{K_ERR, 32'(0)};
        chk_cnt++;
        if (npulse > 1) begin
          $display("FAIL multi_pulse: got %0d pulses in one cycle, expected 1 (t=%0t)", npulse, $time);
        end else if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got kind=%0d data=0x%0h, expected none (t=%0t)",
                   obs.kind, obs.data, $time);
        end else begin
          e = exp_q.pop_front();
          if (obs.kind !== e.kind || obs.data !== e.data)
            $display("FAIL event: got kind=%0d data=0x%0h, expected kind=%0d data=0x%0h (t=%0t)",
                     obs.kind, obs.data, e.kind, e.data, $time);
          else
            pass_cnt++;
        end
      end
    end
  end

  function automatic void ex(input logic [1:0] k, input int d);
    exp_q.push_back('{k, 32'(d)});
  endfunction

  function automatic void ex_vals(input string s);
    for (int i = 0; i < s.len(); i++) ex(K_VAL, int'(s[i]));
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    data_i  = b;
    valid_i = 1'b1;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      send_byte(s[i]);
    end
  endtask

  // Bounded wait for all queued events, then require the queue empty
  task automatic drain(input string name);
    int n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: %0d expected events outstanding, expected 0", name, exp_q.size());
    else
      pass_cnt++;
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    chk_cnt++;
    if (tag_o !== '0 || tag_valid_o !== 1'b0 || val_data_o !== '0 || val_valid_o !== 1'b0 ||
        field_end_o !== 1'b0 || val_len_o !== '0 || err_o !== 1'b0)
      $display("FAIL %s: outputs tag=%0d tv=%b vd=0x%0h vv=%b fe=%b len=%0d err=%b, expected all 0",
               name, tag_o, tag_valid_o, val_data_o, val_valid_o, field_end_o, val_len_o, err_o);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_i = 1'b0; data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    ex(K_TAG, 35); ex_vals("D"); ex(K_END, 1);
    send_str("35=D\001", 1'b0);
    drain("basic");
  endtask

  task automatic test_gaps();
    ex(K_TAG, 8); ex_vals("FIX.4.2"); ex(K_END, 7);
    ex(K_TAG, 9); ex_vals("65"); ex(K_END, 2);
    send_str("8=FIX.4.2\0019=65\001", 1'b1);
    drain("gaps");
  endtask

  task automatic test_bad_eq();
    ex(K_ERR, 0);
    ex(K_TAG, 49); ex_vals("AB"); ex(K_END, 2);
    send_str("=5\00149=AB\001", 1'b0);
    drain("bad_eq");
  endtask

  task automatic test_tag_digits();
    ex(K_ERR, 0);
    ex(K_TAG, 99999); ex_vals("Z"); ex(K_END, 1);
    send_str("123456=X\00199999=Z\001", 1'b0);
    drain("tag_digits");
  endtask

  task automatic test_empty_value();
    ex(K_TAG, 52); ex(K_ERR, 0);
    ex(K_ERR, 0);
    ex(K_TAG, 10); ex_vals("1"); ex(K_END, 1);
    send_str("52=\00152\00110=1\001", 1'b0);
    drain("empty_value");
  endtask

  task automatic test_mid_reset();
    ex(K_TAG, 11); ex_vals("ABC");
    send_str("11=ABC", 1'b0);
    drain("pre_reset");
    #1;
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset_async");
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("mid_reset_hold");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    ex(K_TAG, 55); ex_vals("Q"); ex(K_END, 1);
    send_str("55=Q\001", 1'b0);
    drain("post_reset");
  endtask

  // 64 value bytes is legal; the 65th errors without being forwarded
  task automatic test_val_len();
    string v64;
    string v65;
    byte   c;
    v64 = "";
    for (int i = 0; i < 64; i++) begin
      c = byte'($urandom_range(8'h20, 8'h7E));
      v64 = {v64, string'(c)};
    end
    v65 = {v64, "x"};
    ex(K_TAG, 7); ex_vals(v64); ex(K_END, 64);
    ex(K_TAG, 7); ex_vals(v64); ex(K_ERR, 0);
    ex(K_TAG, 3); ex_vals("ok"); ex(K_END, 2);
    send_str({"7=", v64, "\001", "7=", v65, "yz\001", "3=ok\001"}, 1'b0);
    drain("val_len");
  endtask

  task automatic test_back_to_back();
    ex(K_TAG, 1);   ex_vals("a");     ex(K_END, 1);
    ex(K_TAG, 270); ex_vals("=9");    ex(K_END, 2);
    ex(K_ERR, 0);
    ex(K_TAG, 0);   ex_vals("z");     ex(K_END, 1);
    ex(K_TAG, 44);  ex_vals("12.5");  ex(K_END, 4);
    send_str("1=a\001270==9\001A=b\0010=z\00144=12.5\001", 1'b0);
    drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bad_eq();
    test_tag_digits();
    test_empty_value();
    test_mid_reset();
    test_val_len();
    test_back_to_back();
    idle(3);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
